regfile_mp: RTL

- Parametrised successor to the 3-port register file: NRD read ports, NWR write ports, configurable width and depth.
- Register 0 is hardwired to zero.
- Adds a per-register pending-write scoreboard (set at issue, cleared at writeback) and a pending-count output, so the pipeline can stall on RAW hazards without external tracking.
- Sits between decode (reads, issue) and writeback (writes) in the core.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_mp.sv | 65 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, register word type and pending-vector popcount
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    localparam int POP_W = 256;
    typedef logic [XLEN_DEF-1:0] word_t;
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits (issue sets, writeback clears, set wins)
// and a registered count of pending registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR = 1,
    parameter int AW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NWR-1:0]         we_i,
    input  logic [NWR-1:0][AW-1:0] wa_i,
    input  logic                   iss_en_i,
    input  logic [AW-1:0]          iss_rd_i,
    output logic [NREGS-1:0]       pend_o,
    output logic [AW:0]            pend_cnt_o
);
    localparam int CW = AW + 1;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [POP_W-1:0] pend_ext;
    logic [AW:0] cnt_q;
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NWR; i++)
            if (we_i[i]) pend_d[wa_i[i]] = 1'b0;
        if (iss_en_i) pend_d[iss_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
        pend_ext = '0;
        pend_ext[NREGS-1:0] = pend_d;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            cnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q <= CW'(popcount(pend_ext));
        end
    end
    assign pend_o = pend_q;
    assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (reg 0 hardwired to zero) with RAW scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2,
    parameter int NWR = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NRD-1:0][AW-1:0]   ra,
    output logic [NRD-1:0][XLEN-1:0] rd,
    output logic [NRD-1:0]           rdy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   wa,
    input  logic [NWR-1:0][XLEN-1:0] wd,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_rd,
    output logic [AW:0]              pend_cnt
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend;

    regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
        .clk(clk),
        .reset_n(reset_n),
        .we_i(we),
        .wa_i(wa),
        .iss_en_i(iss_en),
        .iss_rd_i(iss_rd),
        .pend_o(pend),
        .pend_cnt_o(pend_cnt)
    );

    // later ports overwrite earlier ones, so the highest index wins a collision
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++)
            if (we[i]) regs_d[wa[i]] = wd[i];
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd[j] = regs_q[ra[j]];
            rdy[j] = ~pend[ra[j]];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWR; i++)
                if (we[i] && wa[i] == ra[j] && ra[j] != '0) begin
                    rd[j] = wd[i];
                    rdy[j] = !(iss_en && iss_rd == ra[j]);
                end
`endif
        end
    end
endmodule
